// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - MMIO byte-store UART transmitter, 8N1, LSB first, with FIFO
// Optional sticky overrun flag in STATUS[3] when built with MMIO_UART_OVERRUN_EN defined.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        hit,
    output logic [31:0] rd_data,
    output logic        tx
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic [7:0]      fifo_mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [PW:0]     count;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            tx_q;
    logic            full, empty, busy, overrun;
    logic            data_hit, push, pop, baud_end;
    logic            unused_wdata;

    assign unused_wdata = ^mem_wdata[31:8];

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign busy     = (state != IDLE);
    assign data_hit = mem_write && (mem_addr == BASE_ADDR);
    // Full comes from the pre-edge count, so a store never rides on a same-cycle pop.
    assign push     = data_hit && !full;
    assign baud_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));

    assign hit     = (mem_addr[31:3] == BASE_ADDR[31:3]);
    assign rd_data = (mem_addr == BASE_ADDR + 32'd4) ? {28'd0, overrun, empty, busy, full} : 32'd0;
    assign tx      = tx_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop        = 1'b1;
                state_next = START;
            end
            START: if (baud_end) state_next = DATA;
            DATA:  if (baud_end && bit_cnt == 3'd7) state_next = STOP;
            STOP: if (baud_end) begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The popped byte lives in shreg for the whole frame; later stores only touch the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else if (pop) begin
            shreg    <= fifo_mem[rd_ptr];
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b0;
        end else if (state != IDLE) begin
            if (baud_end) begin
                baud_cnt <= '0;
                case (state)
                    START: begin
                        tx_q  <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                    DATA: begin
                        if (bit_cnt == 3'd7) begin
                            tx_q <= 1'b1;
                        end else begin
                            tx_q    <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: tx_q <= 1'b1;
                endcase
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

`ifdef MMIO_UART_OVERRUN_EN
    logic status_store;
    assign status_store = mem_write && (mem_addr == BASE_ADDR + 32'd4);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                overrun <= 1'b0;
        else if (data_hit && full)   overrun <= 1'b1;
        else if (status_store)       overrun <= 1'b0;
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - randomized self-checking bench for mmio_uart_tx against a queue/timer model
module tb_mmio_uart_tx;
    localparam int          C    = 4;
    localparam int          D    = 4;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] STAT = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        hit;
    logic [31:0] rd_data;
    logic        tx;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q[$];
    int         timer = 0;
    logic [7:0] cur = 8'h00;
    bit         ovr = 1'b0;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .hit(hit), .rd_data(rd_data), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'd0;
        s[0] = (q.size() == D);
        s[1] = (timer > 0);
        s[2] = (q.size() == 0);
        s[3] = ovr;
        return s;
    endfunction

    // Line level from elapsed time in the current frame: start, 8 data bits, stop.
    function automatic logic model_tx();
        int b;
        if (timer == 0) return 1'b1;
        b = (10*C - timer) / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input bit w, input logic [31:0] a, input logic [31:0] d);
        int  pre;
        bit  pop_now, push_now, set_ovr;
        pre      = q.size();
        pop_now  = (pre > 0) && (timer == 0 || timer == 1);
        push_now = w && (a == BASE) && (pre < D);
        set_ovr  = w && (a == BASE) && (pre == D);
`ifdef MMIO_UART_OVERRUN_EN
        if (w && a == STAT) ovr = 1'b0;
        if (set_ovr)        ovr = 1'b1;
`endif
        if (pop_now) begin
            cur   = q.pop_front();
            timer = 10*C;
        end else if (timer > 0) begin
            timer--;
        end
        if (push_now) q.push_back(d[7:0]);
    endtask

    task automatic step(input bit w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_write = w;
        mem_addr  = a;
        mem_wdata = d;
        #1;
        check("hit", {31'd0, hit}, {31'd0, a[31:3] == BASE[31:3]});
        check("rd_data", rd_data, (a == STAT) ? model_status() : 32'd0);
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        check("tx", {31'd0, tx}, {31'd0, model_tx()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, STAT, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        mem_write = 1'b0;
        #1;
        check("tx_in_reset", {31'd0, tx}, 32'd1);
        q.delete();
        timer = 0;
        ovr   = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        int r;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // Single frame, then back-to-back pair
        step(1'b1, BASE, 32'h0000_0055);
        idle(45);
        step(1'b1, BASE, 32'h0000_0041);
        step(1'b1, BASE, 32'h0000_0042);
        idle(85);

        // Overfill while busy, read STATUS, clear overrun, drain
        for (int i = 0; i < 7; i++) step(1'b1, BASE, 32'hA0 + i);
        idle(3);
        step(1'b1, STAT, 32'd0);
        idle(3);
        step(1'b0, BASE, 32'd0);
        idle(5*10*C + 10);

        // Spram and misaligned addresses must not queue anything
        step(1'b1, 32'd96, 32'h11);
        step(1'b1, 32'd100, 32'h22);
        step(1'b1, BASE + 32'd1, 32'h33);
        step(1'b1, BASE + 32'd6, 32'h44);
        idle(10);

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 7))
                0, 1:    a = BASE;
                2:       a = STAT;
                3:       a = BASE + 32'($urandom_range(1, 7));
                4:       a = 32'd96;
                5:       a = $urandom;
                default: a = STAT;
            endcase
            step(r < 25, a, $urandom);
        end
        idle(5*10*C + 10);

        // Reset landing in data bit 3 abandons the frame and the queue
        step(1'b1, BASE, 32'h0000_00C3);
        step(1'b1, BASE, 32'h0000_005A);
        idle(18);
        do_reset();
        idle(50);

        // Fill FIFO behind an active frame, no overrun
        for (int i = 0; i < 5; i++) step(1'b1, BASE, 32'h30 + i);
        step(1'b0, STAT, 32'd0);
        step(1'b0, BASE, 32'd0);
        idle(5*10*C + 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
